// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome, BTB sweep state and the BTB entry layout.
// ADDR_WIDTH is the core-wide fetch address width.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

    localparam int ADDR_W = `ADDR_WIDTH;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } BtbState;

    // Tag is stored as the PC shifted down past the index, zero-extended,
    // so the layout does not depend on the table depth.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] tag;
        logic [ADDR_W-1:0] target;
        logic [1:0]        ctr;
    } btb_entry_t;

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input BranchOutcome outcome);
        logic [1:0] result;
        result = ctr;
        if (outcome == TAKEN) begin
            if (ctr != 2'b11) result = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) result = ctr - 2'b01;
        end
        return result;
    endfunction

endpackage

// File: rtl/btb_clear_fsm.sv
// Invalidation sweep controller: walks clr_idx over every entry while in CLEAR,
// then holds READY until a flush or reset restarts the sweep at entry 0.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module btb_clear_fsm
    import mips_core_pkg::*;
#(
    parameter int ENTRIES = 64,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    output logic             ready,
    output logic             clr_valid,
    output logic [IDX_W-1:0] clr_idx
);

    BtbState          state_reg;
    BtbState          state_next;
    logic [IDX_W-1:0] clr_idx_reg;
    logic [IDX_W-1:0] clr_idx_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= CLEAR;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        if (i_flush) begin
            state_next   = CLEAR;
            clr_idx_next = '0;
        end else if (state_reg == CLEAR) begin
            if (clr_idx_reg == IDX_W'(ENTRIES - 1)) begin
                state_next   = READY;
                clr_idx_next = '0;
            end else begin
                clr_idx_next = clr_idx_reg + IDX_W'(1);
            end
        end
    end

    assign ready     = (state_reg == READY);
    assign clr_valid = (state_reg == CLEAR);
    assign clr_idx   = clr_idx_reg;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters, zero-latency
// lookup, resolved-branch update port, sweep-based invalidation and hit statistics.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_target_buffer
    import mips_core_pkg::*;
#(
    parameter int ENTRIES   = 64,
    parameter int CTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_lookup_valid,
    input  logic [`ADDR_WIDTH-1:0] i_lookup_pc,
    output logic                   o_ready,
    output logic                   o_hit,
    output BranchOutcome           o_prediction,
    output logic [`ADDR_WIDTH-1:0] o_target,
    input  logic                   i_upd_valid,
    input  logic [`ADDR_WIDTH-1:0] i_upd_pc,
    input  logic [`ADDR_WIDTH-1:0] i_upd_target,
    input  BranchOutcome           i_upd_outcome,
    input  logic                   i_upd_is_jump,
    output logic [CTR_WIDTH-1:0]   o_lookup_count,
    output logic [CTR_WIDTH-1:0]   o_hit_count
);

    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int TAG_LSB = IDX_W + 2;

    logic             ready;
    logic             clr_valid;
    logic [IDX_W-1:0] clr_idx;

    btb_clear_fsm #(
        .ENTRIES (ENTRIES)
    ) u_clear_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (i_flush),
        .ready     (ready),
        .clr_valid (clr_valid),
        .clr_idx   (clr_idx)
    );

    // Entry storage has no reset; valid bits are cleared only by the sweep.
    btb_entry_t btb_mem [ENTRIES];

    // ---------------- lookup ----------------
    logic [IDX_W-1:0]  lk_idx;
    logic [ADDR_W-1:0] lk_tag;
    btb_entry_t        lk_entry;
    logic              lk_hit;
    logic              lk_taken;

    assign lk_idx   = i_lookup_pc[TAG_LSB-1:2];
    assign lk_tag   = ADDR_W'(i_lookup_pc >> TAG_LSB);
    assign lk_entry = btb_mem[lk_idx];
    assign lk_hit   = ready & i_lookup_valid & lk_entry.valid & (lk_entry.tag == lk_tag);
    assign lk_taken = lk_hit & lk_entry.ctr[1];

    assign o_ready      = ready;
    assign o_hit        = lk_hit;
    assign o_prediction = lk_taken ? TAKEN : NOT_TAKEN;
    assign o_target     = lk_taken ? lk_entry.target : i_lookup_pc + `ADDR_WIDTH'(8);

    // ---------------- update ----------------
    logic [IDX_W-1:0]  upd_idx;
    logic [ADDR_W-1:0] upd_tag;
    logic              upd_en;
    logic              upd_hit;
    logic              upd_we;
    btb_entry_t        upd_rd;
    btb_entry_t        upd_wr;

    assign upd_idx = i_upd_pc[TAG_LSB-1:2];
    assign upd_tag = ADDR_W'(i_upd_pc >> TAG_LSB);
    assign upd_en  = i_upd_valid & ready & ~i_flush;
    assign upd_rd  = btb_mem[upd_idx];
    assign upd_hit = upd_rd.valid & (upd_rd.tag == upd_tag);

    always_comb begin
        upd_we = 1'b0;
        upd_wr = upd_rd;
        if (upd_en) begin
            if (i_upd_is_jump) begin
                upd_we        = 1'b1;
                upd_wr.valid  = 1'b1;
                upd_wr.tag    = upd_tag;
                upd_wr.target = i_upd_target;
                upd_wr.ctr    = 2'b11;
            end else if (upd_hit) begin
                upd_we     = 1'b1;
                upd_wr.ctr = ctr_step(upd_rd.ctr, i_upd_outcome);
                if (i_upd_outcome == TAKEN) upd_wr.target = i_upd_target;
            end else if (i_upd_outcome == TAKEN) begin
                // Allocation on a taken miss evicts whatever alias held the slot.
                upd_we        = 1'b1;
                upd_wr.valid  = 1'b1;
                upd_wr.tag    = upd_tag;
                upd_wr.target = i_upd_target;
                upd_wr.ctr    = 2'b10;
            end
        end
    end

    // Sweep and update never collide: updates are only accepted in READY.
    always_ff @(posedge clk) begin
        if (clr_valid) begin
            btb_mem[clr_idx].valid <= 1'b0;
        end else if (upd_we) begin
            btb_mem[upd_idx] <= upd_wr;
        end
    end

    // ---------------- statistics ----------------
    logic [CTR_WIDTH-1:0] lookup_cnt_reg;
    logic [CTR_WIDTH-1:0] hit_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_cnt_reg <= '0;
            hit_cnt_reg    <= '0;
        end else begin
            if (i_lookup_valid && ready && !(&lookup_cnt_reg))
                lookup_cnt_reg <= lookup_cnt_reg + CTR_WIDTH'(1);
            if (lk_hit && !(&hit_cnt_reg))
                hit_cnt_reg <= hit_cnt_reg + CTR_WIDTH'(1);
        end
    end

    assign o_lookup_count = lookup_cnt_reg;
    assign o_hit_count    = hit_cnt_reg;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed and randomized check of branch_target_buffer against a table-level
// behavioural model of prediction, allocation, sweep timing and statistics.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_branch_target_buffer;
    import mips_core_pkg::*;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_flush;
    logic         i_lookup_valid;
    logic [31:0]  i_lookup_pc;
    logic         o_ready;
    logic         o_hit;
    BranchOutcome o_prediction;
    logic [31:0]  o_target;
    logic         i_upd_valid;
    logic [31:0]  i_upd_pc;
    logic [31:0]  i_upd_target;
    BranchOutcome i_upd_outcome;
    logic         i_upd_is_jump;
    logic [31:0]  o_lookup_count;
    logic [31:0]  o_hit_count;

    always #5 clk = ~clk;

    branch_target_buffer #(.ENTRIES(N), .CTR_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_flush        (i_flush),
        .i_lookup_valid (i_lookup_valid),
        .i_lookup_pc    (i_lookup_pc),
        .o_ready        (o_ready),
        .o_hit          (o_hit),
        .o_prediction   (o_prediction),
        .o_target       (o_target),
        .i_upd_valid    (i_upd_valid),
        .i_upd_pc       (i_upd_pc),
        .i_upd_target   (i_upd_target),
        .i_upd_outcome  (i_upd_outcome),
        .i_upd_is_jump  (i_upd_is_jump),
        .o_lookup_count (o_lookup_count),
        .o_hit_count    (o_hit_count)
    );

    // Reference model: table contents, cycles left before usable, statistics.
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    int          m_left;
    int unsigned m_lk_cnt;
    int unsigned m_hit_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic        s_ready, s_hit;
    logic [31:0] s_pred, s_tgt;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * N);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_clear_all();
        for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
        m_left = N;
    endtask

    task automatic model_update(input logic [31:0] upc, input logic [31:0] utgt,
                                input BranchOutcome uo, input bit uj);
        int  j;
        bit  h;
        j = idx_of(upc);
        h = m_valid[j] && (m_tag[j] == tag_of(upc));
        if (uj) begin
            m_valid[j] = 1'b1; m_tag[j] = tag_of(upc); m_tgt[j] = utgt; m_ctr[j] = 3;
        end else if (h) begin
            if (uo == TAKEN) begin
                m_ctr[j] = (m_ctr[j] < 3) ? m_ctr[j] + 1 : 3;
                m_tgt[j] = utgt;
            end else begin
                m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
            end
        end else if (uo == TAKEN) begin
            m_valid[j] = 1'b1; m_tag[j] = tag_of(upc); m_tgt[j] = utgt; m_ctr[j] = 2;
        end
    endtask

    // One clock cycle: drive, check outputs at the falling edge, advance model at the rising edge.
    task automatic step(input bit fl, input bit lv, input logic [31:0] lpc,
                        input bit uv, input logic [31:0] upc, input logic [31:0] utgt,
                        input BranchOutcome uo, input bit uj);
        bit          e_ready, e_hit, e_pred;
        logic [31:0] e_tgt;
        int          i;
        i_flush = fl; i_lookup_valid = lv; i_lookup_pc = lpc;
        i_upd_valid = uv; i_upd_pc = upc; i_upd_target = utgt;
        i_upd_outcome = uo; i_upd_is_jump = uj;
        @(negedge clk);
        i       = idx_of(lpc);
        e_ready = (m_left == 0);
        e_hit   = e_ready && lv && m_valid[i] && (m_tag[i] == tag_of(lpc));
        e_pred  = e_hit && (m_ctr[i] >= 2);
        e_tgt   = e_pred ? m_tgt[i] : lpc + 32'd8;
        check("ready", 32'(o_ready), 32'(e_ready));
        check("hit", 32'(o_hit), 32'(e_hit));
        check("prediction", 32'(o_prediction), 32'(e_pred));
        check("target", o_target, e_tgt);
        check("lookup_count", o_lookup_count, m_lk_cnt);
        check("hit_count", o_hit_count, m_hit_cnt);
        s_ready = o_ready; s_hit = o_hit; s_pred = 32'(o_prediction); s_tgt = o_target;
        @(posedge clk);
        if (lv && e_ready) m_lk_cnt++;
        if (e_hit) m_hit_cnt++;
        if (fl) model_clear_all();
        else if (!e_ready) m_left--;
        else if (uv) model_update(upc, utgt, uo, uj);
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        step(1'b0, 1'b1, pc, 1'b0, 32'h0, 32'h0, NOT_TAKEN, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input BranchOutcome uo);
        step(1'b0, 1'b0, 32'h0, 1'b1, pc, tgt, uo, 1'b0);
    endtask

    logic [31:0] rpc, rupc, rtgt;

    initial begin
        rst_n = 1'b0;
        i_flush = 0; i_lookup_valid = 0; i_lookup_pc = 0;
        i_upd_valid = 0; i_upd_pc = 0; i_upd_target = 0;
        i_upd_outcome = NOT_TAKEN; i_upd_is_jump = 0;
        m_lk_cnt = 0; m_hit_cnt = 0;
        model_clear_all();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(o_ready), 32'h0);
        check("reset_pred", 32'(o_prediction), 32'(NOT_TAKEN));
        check("reset_lookup_count", o_lookup_count, 32'h0);
        check("reset_hit_count", o_hit_count, 32'h0);
        rst_n = 1'b1;

        // Sweep after release, then a lookup on the empty table.
        repeat (N) look(32'h0040_0010);
        look(32'h0040_0010);
        check("first_ready", 32'(s_ready), 32'h1);
        check("first_hit", 32'(s_hit), 32'h0);
        check("first_target", s_tgt, 32'h0040_0018);

        // Allocate, predict taken, then train down to not-taken.
        upd(32'h0040_0010, 32'h0040_0100, TAKEN);
        look(32'h0040_0010);
        check("alloc_hit", 32'(s_hit), 32'h1);
        check("alloc_pred", s_pred, 32'(TAKEN));
        check("alloc_target", s_tgt, 32'h0040_0100);
        upd(32'h0040_0010, 32'h0040_0100, NOT_TAKEN);
        upd(32'h0040_0010, 32'h0040_0100, NOT_TAKEN);
        look(32'h0040_0010);
        check("trained_hit", 32'(s_hit), 32'h1);
        check("trained_pred", s_pred, 32'(NOT_TAKEN));
        check("trained_target", s_tgt, 32'h0040_0018);

        // Alias on index 4 evicts the original entry.
        look(32'h0040_0110);
        check("alias_miss", 32'(s_hit), 32'h0);
        upd(32'h0040_0110, 32'h0040_0200, TAKEN);
        look(32'h0040_0010);
        check("evicted_miss", 32'(s_hit), 32'h0);

        // Same-cycle update and lookup: no bypass.
        step(1'b0, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0020, 32'h0040_0300, TAKEN, 1'b0);
        check("nobypass_miss", 32'(s_hit), 32'h0);
        look(32'h0040_0020);
        check("nobypass_hit_next", 32'(s_hit), 32'h1);

        // Flush beats a simultaneous update.
        step(1'b1, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0030, 32'h0040_0400, TAKEN, 1'b0);
        repeat (N) look(32'h0040_0020);
        look(32'h0040_0030);
        check("flush_drop_miss", 32'(s_hit), 32'h0);

        // Randomized traffic over a small PC pool to force hits, aliases and jumps.
        for (int n = 0; n < 600; n++) begin
            rpc  = 32'h0040_0000 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 7) << 2);
            rupc = 32'h0040_0000 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 7) << 2);
            rtgt = 32'h0050_0000 + ($urandom_range(0, 255) << 2);
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), rpc,
                 ($urandom_range(0, 1) == 1), rupc, rtgt,
                 BranchOutcome'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        // Reset between edges in the middle of a sweep.
        step(1'b1, 1'b1, 32'h0040_0010, 1'b0, 32'h0, 32'h0, NOT_TAKEN, 1'b0);
        repeat (20) look(32'h0040_0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("midsweep_rst_ready", 32'(o_ready), 32'h0);
        check("midsweep_rst_hit", 32'(o_hit), 32'h0);
        check("midsweep_rst_lookup_count", o_lookup_count, 32'h0);
        check("midsweep_rst_hit_count", o_hit_count, 32'h0);
        m_lk_cnt = 0; m_hit_cnt = 0;
        model_clear_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (N) look(32'h0040_0010);
        for (int n = 0; n < 100; n++) begin
            rpc  = 32'h0040_0000 + ($urandom_range(0, 1) << 8) + ($urandom_range(0, 3) << 2);
            step(1'b0, 1'b1, rpc, 1'b1, rpc, rpc + 32'h100,
                 BranchOutcome'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, number of direct-mapped entries (power of two, >=4).
REQ-002 SHALL have parameter CTR_WIDTH, default 32, width of each statistics counter.
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port i_flush, input, 1, request to invalidate all entries.
REQ-006 Port i_lookup_valid, input, 1, fetch lookup request qualifier.
REQ-007 Port i_lookup_pc, input, `ADDR_WIDTH, fetch PC to look up.
REQ-008 Port o_ready, output, 1, high when the table is usable (READY state).
REQ-009 Port o_hit, output, 1, valid entry with matching tag.
REQ-010 Port o_prediction, output, BranchOutcome, predicted direction.
REQ-011 Port o_target, output, `ADDR_WIDTH, predicted next fetch address.
REQ-012 Port i_upd_valid, input, 1, resolved-branch feedback valid (from EX).
REQ-013 Port i_upd_pc, i_upd_target, inputs, `ADDR_WIDTH each, resolved branch PC and taken target.
REQ-014 Port i_upd_outcome, input, BranchOutcome, resolved direction.
REQ-015 Port i_upd_is_jump, input, 1, resolved instruction is an unconditional jump.
REQ-016 Ports o_lookup_count, o_hit_count, outputs, CTR_WIDTH each, statistics.

Function
REQ-017 Index SHALL be pc[log2(ENTRIES)+1:2]; tag SHALL be pc[`ADDR_WIDTH-1:log2(ENTRIES)+2].
REQ-018 Each entry SHALL hold valid, tag, target, 2-bit saturating counter.
REQ-019 Lookup SHALL be combinational, zero latency: o_hit = o_ready & i_lookup_valid & valid & tag match.
REQ-020 o_prediction SHALL be TAKEN iff o_hit and counter[1]; otherwise NOT_TAKEN.
REQ-021 o_target SHALL be entry target when o_prediction is TAKEN, else i_lookup_pc + 8.
REQ-022 Update (i_upd_valid, READY, no flush) on hit: counter +1 saturating at 2'b11 if TAKEN, -1 saturating at 2'b00 if NOT_TAKEN; target overwritten only if TAKEN.
REQ-023 Update on miss: TAKEN allocates (valid=1, tag, target, counter=2'b10), replacing any alias; NOT_TAKEN leaves the table unchanged.
REQ-024 i_upd_is_jump SHALL force counter to 2'b11 and write target, hit or miss.
REQ-025 Lookup and update in the same cycle to the same index SHALL return pre-update contents (no bypass); the update is visible the next cycle.
REQ-026 FSM states CLEAR, READY; CLEAR invalidates entry clr_idx each cycle, clr_idx 0..ENTRIES-1, then READY after exactly ENTRIES cycles.
REQ-027 i_flush in READY SHALL enter CLEAR with clr_idx=0; i_flush in CLEAR SHALL restart clr_idx at 0.
REQ-028 i_flush with simultaneous update: flush wins, update dropped.
REQ-029 In CLEAR: o_ready=0, o_hit=0, updates dropped.
REQ-030 o_lookup_count SHALL increment per cycle with i_lookup_valid & o_ready; o_hit_count per cycle with o_hit; both saturate at all-ones.

Reset
REQ-031 rst_n low SHALL immediately, without a clock edge: FSM=CLEAR, clr_idx=0, o_ready=0, o_hit=0, o_prediction=NOT_TAKEN, both counters 0.
REQ-032 Entry valid bits SHALL be cleared by the CLEAR sweep, not by reset; tag/target/counter storage is not reset.
REQ-033 Reset asserted mid-sweep or mid-update SHALL abandon the operation and restart the sweep at 0 after release.

Structure
REQ-034 BtbState enum (CLEAR, READY) and btb_entry_t struct SHALL live in mips_core_pkg; BranchOutcome reused from it.
REQ-035 Sweep FSM and clr_idx SHALL be sub-module btb_clear_fsm (outputs ready, clr_valid, clr_idx).

Verification
REQ-036 Release rst_n: o_ready=0 for 64 cycles then 1; lookup 0x0040_0010 -> o_hit=0, NOT_TAKEN, o_target=0x0040_0018.
REQ-037 Update 0x0040_0010 TAKEN target 0x0040_0100; next cycle lookup -> hit, TAKEN, 0x0040_0100; two NOT_TAKEN updates -> hit=1, NOT_TAKEN, target 0x0040_0018.
REQ-038 Alias: after REQ-037 allocation, lookup 0x0040_0110 (index 4, new tag) -> miss; TAKEN update to it then lookup 0x0040_0010 -> miss.
REQ-039 Same-cycle update TAKEN and lookup of 0x0040_0020 on empty entry -> miss that cycle, hit next cycle.
REQ-040 i_flush with simultaneous TAKEN update 0x0040_0030 -> o_ready low 64 cycles, then lookup 0x0040_0030 misses; o_hit_count unchanged during CLEAR.
REQ-041 Assert rst_n between clock edges at clr_idx=20 -> o_ready, counters 0 immediately; full 64-cycle sweep after release.
